led_blink_sched: RTL and testbench

Round-robin scheduler that shares a single board LED among NUM_REQ requesters. Each requester asks for a blink sequence: a half-period in ticks and a number of blinks. The block grants one requester at a time, runs that sequence on the LED using an internal tick prescaler, then signals completion. It sits between software/debug status sources and the LED pin, and replaces free-running per-LED blinkers.

---
 rtl/led_blink_sched.sv | 195 +++++++++++++++++++
 tb/tb_led_blink_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/led_blink_sched.sv
`default_nettype none
// ============================================================================
//  Module      : led_blink_sched
//  Description : Round-robin owner of one board LED; the granted requester's
//                blink sequence is played on a tick prescaler, then released.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_blink_sched #(
    parameter int NUM_REQ   = 4,
    parameter int TICK_DIV  = 5,
    parameter int PW        = 16,
    parameter int CW        = 8,
    parameter int GAP_TICKS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*PW-1:0] period,
    input  logic [NUM_REQ*CW-1:0] blinks,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    done,
    output logic                  busy,
    output logic                  led
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DW-1:0]      C_TICK_LAST = DW'(TICK_DIV - 1);
    localparam logic [DW-1:0]      C_DIV_ONE   = DW'(1);
    localparam logic [PW-1:0]      C_P_ONE     = PW'(1);
    localparam logic [CW-1:0]      C_C_ONE     = CW'(1);
    localparam logic [PW-1:0]      C_GAP_LAST  = (GAP_TICKS > 0) ? PW'(GAP_TICKS - 1) : '0;
    localparam logic [IW-1:0]      C_LAST_RST  = IW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] C_ONEHOT0   = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t               state_q,     state_d;
    logic [DW-1:0]        pre_q,       pre_d;
    logic [PW-1:0]        phase_q,     phase_d;
    logic [PW-1:0]        period_q,    period_d;
    logic [CW-1:0]        remaining_q, remaining_d;
    logic [IW-1:0]        owner_q,     owner_d;
    logic [IW-1:0]        last_q,      last_d;
    logic                 aborted_q,   aborted_d;
    logic [NUM_REQ-1:0]   grant_q,     grant_d;
    logic [NUM_REQ-1:0]   done_q,      done_d;
    logic                 busy_q,      busy_d;
    logic                 led_q,       led_d;

    logic                 w_tick;
    logic                 w_found;
    logic [IW-1:0]        w_win;
    logic [PW-1:0]        w_win_period;
    logic [CW-1:0]        w_win_blinks;
    logic                 w_phase_end;

    // Rotating search starting just after the previous owner.
    always_comb begin
        w_found = 1'b0;
        w_win   = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = IW'(idx);
            end
        end
    end

    assign w_win_period = period[int'(w_win)*PW +: PW];
    assign w_win_blinks = blinks[int'(w_win)*CW +: CW];
    assign w_tick       = (pre_q == C_TICK_LAST);
    assign w_phase_end  = (phase_q == period_q - C_P_ONE);

    always_comb begin
        state_d     = state_q;
        pre_d       = w_tick ? '0 : pre_q + C_DIV_ONE;
        phase_d     = phase_q;
        period_d    = period_q;
        remaining_d = remaining_q;
        owner_d     = owner_q;
        last_d      = last_q;
        aborted_d   = aborted_q;
        grant_d     = grant_q;
        done_d      = '0;

        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    owner_d     = w_win;
                    last_d      = w_win;
                    grant_d     = C_ONEHOT0 << w_win;
                    period_d    = (w_win_period == '0) ? C_P_ONE : w_win_period;
                    remaining_d = w_win_blinks;
                    aborted_d   = 1'b0;
                    state_d     = (w_win_blinks == '0) ? ST_GAP : ST_ON;
                end
            end
            ST_ON: begin
                if (!req[owner_q]) begin
                    aborted_d = 1'b1;
                    state_d   = ST_GAP;
                end else if (w_tick) begin
                    if (w_phase_end) begin
                        state_d = ST_OFF;
                    end else begin
                        phase_d = phase_q + C_P_ONE;
                    end
                end
            end
            ST_OFF: begin
                if (!req[owner_q]) begin
                    aborted_d = 1'b1;
                    state_d   = ST_GAP;
                end else if (w_tick) begin
                    if (w_phase_end) begin
                        remaining_d = remaining_q - C_C_ONE;
                        state_d     = (remaining_q == C_C_ONE) ? ST_GAP : ST_ON;
                    end else begin
                        phase_d = phase_q + C_P_ONE;
                    end
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    if (phase_q == C_GAP_LAST) begin
                        state_d          = ST_IDLE;
                        grant_d          = '0;
                        done_d[owner_q]  = ~aborted_q;
                    end else begin
                        phase_d = phase_q + C_P_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        // Every phase starts on a fresh prescaler so it lasts whole ticks.
        if (state_d != state_q) begin
            pre_d   = '0;
            phase_d = '0;
        end

        led_d  = (state_d == ST_ON);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pre_q       <= '0;
            phase_q     <= '0;
            period_q    <= C_P_ONE;
            remaining_q <= '0;
            owner_q     <= '0;
            last_q      <= C_LAST_RST;
            aborted_q   <= 1'b0;
            grant_q     <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            phase_q     <= phase_d;
            period_q    <= period_d;
            remaining_q <= remaining_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            aborted_q   <= aborted_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            led_q       <= led_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign led   = led_q;

endmodule
`default_nettype wire

// File: tb/tb_led_blink_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_blink_sched
//  Description : Directed bench for led_blink_sched with hand-derived timelines.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_led_blink_sched;

    localparam int NR = 4;
    localparam int PW = 16;
    localparam int CW = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR*PW-1:0]  period = '0;
    logic [NR*CW-1:0]  blinks = '0;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     done;
    logic              busy;
    logic              led;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    led_blink_sched #(
        .NUM_REQ  (NR),
        .TICK_DIV (5),
        .PW       (PW),
        .CW       (CW),
        .GAP_TICKS(2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .period (period),
        .blinks (blinks),
        .grant  (grant),
        .done   (done),
        .busy   (busy),
        .led    (led)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Packs {grant, done, busy, led}; busy is expected whenever an owner is granted.
    task automatic chk_cycle(input string tag, input int c, input logic [NR-1:0] eg,
                             input logic [NR-1:0] ed, input logic el);
        check_eq($sformatf("%s c%0d", tag, c), {22'd0, grant, done, busy, led},
                 {22'd0, eg, ed, |eg, el});
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        req    = '0;
        period = '0;
        blinks = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    initial begin
        logic [NR-1:0] eg;
        logic [NR-1:0] ed;
        logic          el;

        @(negedge clk);
        check_eq("reset", {22'd0, grant, done, busy, led}, 32'd0);

        // Single requester: period 2, three blinks.
        apply_reset();
        period[0*PW +: PW] = 16'd2;
        blinks[0*CW +: CW] = 8'd3;
        req = 4'b0001;
        for (int c = 1; c <= 72; c++) begin
            next_cycle();
            eg = (c <= 70) ? 4'b0001 : 4'b0000;
            ed = (c == 71) ? 4'b0001 : 4'b0000;
            el = in_rng(c, 1, 10) || in_rng(c, 21, 30) || in_rng(c, 41, 50);
            chk_cycle("single", c, eg, ed, el);
            if (c == 71) req[0] = 1'b0;
        end

        // Contention: req0 and req2 held; rotation hands over to req2, then back.
        apply_reset();
        period[0*PW +: PW] = 16'd1;
        blinks[0*CW +: CW] = 8'd1;
        period[2*PW +: PW] = 16'd1;
        blinks[2*CW +: CW] = 8'd1;
        req = 4'b0101;
        for (int c = 1; c <= 43; c++) begin
            next_cycle();
            eg = in_rng(c, 1, 20)  ? 4'b0001 :
                 in_rng(c, 22, 41) ? 4'b0100 :
                 (c == 43)         ? 4'b0001 : 4'b0000;
            ed = (c == 21) ? 4'b0001 : (c == 42) ? 4'b0100 : 4'b0000;
            el = in_rng(c, 1, 5) || in_rng(c, 22, 26) || (c == 43);
            chk_cycle("contend", c, eg, ed, el);
            if (c == 42) req[2] = 1'b0;
        end

        // Zero blinks: only the gap runs, then done.
        apply_reset();
        period[1*PW +: PW] = 16'd3;
        blinks[1*CW +: CW] = 8'd0;
        req = 4'b0010;
        for (int c = 1; c <= 12; c++) begin
            next_cycle();
            eg = (c <= 10) ? 4'b0010 : 4'b0000;
            ed = (c == 11) ? 4'b0010 : 4'b0000;
            chk_cycle("blinks0", c, eg, ed, 1'b0);
            if (c == 11) req[1] = 1'b0;
        end

        // Abort: owner drops its request during the first OFF phase.
        apply_reset();
        period[0*PW +: PW] = 16'd2;
        blinks[0*CW +: CW] = 8'd3;
        req = 4'b0001;
        for (int c = 1; c <= 28; c++) begin
            next_cycle();
            eg = (c <= 25) ? 4'b0001 : 4'b0000;
            chk_cycle("abort", c, eg, 4'b0000, in_rng(c, 1, 10));
            if (c == 15) req[0] = 1'b0;
        end

        // Period 0 behaves as period 1.
        apply_reset();
        period[0*PW +: PW] = 16'd0;
        blinks[0*CW +: CW] = 8'd2;
        req = 4'b0001;
        for (int c = 1; c <= 32; c++) begin
            next_cycle();
            eg = (c <= 30) ? 4'b0001 : 4'b0000;
            ed = (c == 31) ? 4'b0001 : 4'b0000;
            el = in_rng(c, 1, 5) || in_rng(c, 11, 15);
            chk_cycle("period0", c, eg, ed, el);
            if (c == 31) req[0] = 1'b0;
        end

        // Asynchronous reset mid-ON, then req0 wins again over req2.
        apply_reset();
        period[0*PW +: PW] = 16'd2;
        blinks[0*CW +: CW] = 8'd3;
        period[2*PW +: PW] = 16'd2;
        blinks[2*CW +: CW] = 8'd3;
        req = 4'b0001;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            chk_cycle("prerst", c, 4'b0001, 4'b0000, 1'b1);
        end
        req = 4'b0101;
        #1 rst_n = 1'b0;
        #1 check_eq("rst_async", {22'd0, grant, done, busy, led}, 32'd0);
        @(negedge clk);
        check_eq("rst_hold", {22'd0, grant, done, busy, led}, 32'd0);
        rst_n = 1'b1;
        next_cycle();
        chk_cycle("postrst", 1, 4'b0001, 4'b0000, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
